fmul_72bit_result_queue: RTL and testbench

Output buffer placed directly downstream of the 72-bit floating multiplier's exception stage. It accepts finished products over the VALID/BUSY handshake and stores them in a small FIFO. While buffering, it classifies each result as normal, zero, infinity or NaN. It isolates the multiplier pipeline from consumer stalls, so downstream backpressure never propagates combinationally into the multiplier.

---
 rtl/fmul_72bit_result_queue.sv | 97 +++++++++
 tb/tb_fmul_72bit_result_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fmul_72bit_result_queue.sv
// rtl/fmul_72bit_result_queue.sv - result FIFO with IEEE-style class tagging behind the 72-bit multiplier
module fmul_72bit_result_queue #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iRESET_SYNC,
    input  logic                 iDATA_VALID,
    output logic                 oDATA_BUSY,
    input  logic [71:0]          iDATA,
    output logic                 oDATA_VALID,
    input  logic                 iDATA_BUSY,
    output logic [71:0]          oDATA,
    output logic [1:0]           oDATA_CLASS,
    output logic [P_DEPTH_N:0]   oCOUNT
);

    typedef enum logic [1:0] {
        CLASS_NORMAL = 2'd0,
        CLASS_ZERO   = 2'd1,
        CLASS_INF    = 2'd2,
        CLASS_NAN    = 2'd3
    } result_class_t;

    localparam logic [P_DEPTH_N-1:0] PTR_ONE    = P_DEPTH_N'(1);
    localparam logic [P_DEPTH_N:0]   CNT_ONE    = (P_DEPTH_N+1)'(1);
    localparam logic [P_DEPTH_N:0]   CNT_FULL   = (P_DEPTH_N+1)'(P_DEPTH);

    logic [73:0]          mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] wr_ptr;
    logic [P_DEPTH_N-1:0] rd_ptr;
    logic [P_DEPTH_N:0]   count;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    result_class_t in_class;
    logic [73:0]   head;

    // Sign bit plays no part; denormals collapse into the zero class.
    always_comb begin
        in_class = CLASS_NORMAL;
        if (iDATA[70:60] == 11'h7FF) begin
            in_class = (iDATA[59:0] != 60'd0) ? CLASS_NAN : CLASS_INF;
        end else if (iDATA[70:60] == 11'h000) begin
            in_class = CLASS_ZERO;
        end
    end

    // Busy depends only on the registered count, so consumer stalls never
    // reach the multiplier combinationally; a pop at full frees a slot next cycle.
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign push  = iDATA_VALID & ~full;
    assign pop   = ~empty & ~iDATA_BUSY;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (iRESET_SYNC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; the head is masked by the valid flag instead.
    always_ff @(posedge iCLOCK) begin
        if (push && !iRESET_SYNC) begin
            mem[wr_ptr] <= {in_class, iDATA};
        end
    end

    assign head        = mem[rd_ptr];
    assign oDATA_BUSY  = full;
    assign oDATA_VALID = ~empty;
    assign oDATA       = empty ? 72'd0 : head[71:0];
    assign oDATA_CLASS = empty ? 2'd0 : head[73:72];
    assign oCOUNT      = count;

endmodule

// File: tb/tb_fmul_72bit_result_queue.sv
// tb/tb_fmul_72bit_result_queue.sv - directed-vector bench for fmul_72bit_result_queue
module tb_fmul_72bit_result_queue;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iRESET_SYNC = 1'b0;
    logic        iDATA_VALID = 1'b0;
    logic        oDATA_BUSY;
    logic [71:0] iDATA = 72'd0;
    logic        oDATA_VALID;
    logic        iDATA_BUSY = 1'b0;
    logic [71:0] oDATA;
    logic [1:0]  oDATA_CLASS;
    logic [2:0]  oCOUNT;

    int n_vec = 0;
    int n_bad = 0;

    fmul_72bit_result_queue #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iDATA_VALID (iDATA_VALID),
        .oDATA_BUSY  (oDATA_BUSY),
        .iDATA       (iDATA),
        .oDATA_VALID (oDATA_VALID),
        .iDATA_BUSY  (iDATA_BUSY),
        .oDATA       (oDATA),
        .oDATA_CLASS (oDATA_CLASS),
        .oCOUNT      (oCOUNT)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    function automatic logic [71:0] mkword(input logic s, input logic [10:0] e, input logic [59:0] f);
        return {s, e, f};
    endfunction

    task automatic push_word(input logic [71:0] w);
        iDATA_VALID = 1'b1;
        iDATA = w;
        tick();
        iDATA_VALID = 1'b0;
    endtask

    logic [71:0] cw [4];
    logic [71:0] fw [5];
    logic [71:0] sw [10];
    logic [71:0] xw [3];

    initial begin
        cw[0] = mkword(1'b0, 11'h7FF, 60'd1);
        cw[1] = mkword(1'b0, 11'h7FF, 60'd0);
        cw[2] = mkword(1'b0, 11'h000, 60'd5);
        cw[3] = mkword(1'b1, 11'h400, 60'd0);
        for (int i = 0; i < 5; i++) fw[i] = mkword(1'b0, 11'h100 + 11'(i), 60'hABC0 + 60'(i));
        for (int i = 0; i < 10; i++) sw[i] = mkword(1'(i), 11'h200 + 11'(i), 60'h5A5A_0000 + 60'(i));
        for (int i = 0; i < 3; i++) xw[i] = mkword(1'b0, 11'h300 + 11'(i), 60'h77 + 60'(i));

        // reset state
        #2;
        check("rst_valid", 72'(oDATA_VALID), 72'd0);
        check("rst_busy",  72'(oDATA_BUSY),  72'd0);
        check("rst_data",  oDATA,            72'd0);
        check("rst_class", 72'(oDATA_CLASS), 72'd0);
        check("rst_count", 72'(oCOUNT),      72'd0);
        @(negedge iCLOCK);
        inRESET = 1'b1;

        // single word
        push_word(72'h0_3FF_000000000000001);
        check("single_valid", 72'(oDATA_VALID), 72'd1);
        check("single_data",  oDATA, 72'h0_3FF_000000000000001);
        check("single_class", 72'(oDATA_CLASS), 72'd0);
        check("single_count", 72'(oCOUNT), 72'd1);
        tick();
        check("single_pop_count", 72'(oCOUNT), 72'd0);
        check("single_pop_data",  oDATA, 72'd0);

        // classification
        iDATA_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) push_word(cw[i]);
        check("class_count", 72'(oCOUNT), 72'd4);
        iDATA_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("class_data", oDATA, cw[i]);
            check("class_tag",  72'(oDATA_CLASS), 72'(3 - i));
            tick();
        end
        check("class_empty", 72'(oDATA_VALID), 72'd0);

        // fill and stall
        iDATA_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fill_not_busy", 72'(oDATA_BUSY), 72'd0);
            push_word(fw[i]);
        end
        check("fill_busy",  72'(oDATA_BUSY), 72'd1);
        check("fill_count", 72'(oCOUNT), 72'd4);
        iDATA_VALID = 1'b1;
        iDATA = fw[4];
        tick();
        check("fill_held_count", 72'(oCOUNT), 72'd4);
        check("fill_head0", oDATA, fw[0]);
        iDATA_BUSY = 1'b0;
        tick();
        check("fill_first_pop_count", 72'(oCOUNT), 72'd3);
        check("fill_busy_fall", 72'(oDATA_BUSY), 72'd0);
        check("fill_head1", oDATA, fw[1]);
        tick();
        iDATA_VALID = 1'b0;
        check("fill_w4_count", 72'(oCOUNT), 72'd3);
        for (int i = 2; i < 5; i++) begin
            check("fill_order", oDATA, fw[i]);
            tick();
        end
        check("fill_drain", 72'(oCOUNT), 72'd0);

        // streaming wrap
        for (int i = 0; i < 10; i++) begin
            iDATA_VALID = 1'b1;
            iDATA = sw[i];
            tick();
            check("stream_count", 72'(oCOUNT), 72'd1);
            check("stream_data",  oDATA, sw[i]);
        end
        iDATA_VALID = 1'b0;
        tick();
        check("stream_drain", 72'(oCOUNT), 72'd0);

        // simultaneous push and pop at count 2
        iDATA_BUSY = 1'b1;
        push_word(xw[0]);
        push_word(xw[1]);
        check("simul_pre_count", 72'(oCOUNT), 72'd2);
        iDATA_BUSY = 1'b0;
        push_word(xw[2]);
        check("simul_count", 72'(oCOUNT), 72'd2);
        check("simul_head",  oDATA, xw[1]);
        tick();
        check("simul_tail", oDATA, xw[2]);
        tick();
        check("simul_drain", 72'(oCOUNT), 72'd0);

        // synchronous clear overrides a push
        iDATA_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) push_word(fw[i]);
        check("sync_pre_count", 72'(oCOUNT), 72'd3);
        iRESET_SYNC = 1'b1;
        push_word(sw[0]);
        iRESET_SYNC = 1'b0;
        check("sync_count", 72'(oCOUNT), 72'd0);
        check("sync_valid", 72'(oDATA_VALID), 72'd0);
        check("sync_data",  oDATA, 72'd0);
        push_word(sw[1]);
        check("sync_after_head", oDATA, sw[1]);
        check("sync_after_count", 72'(oCOUNT), 72'd1);

        // asynchronous reset between edges, from full
        for (int i = 0; i < 3; i++) push_word(fw[i]);
        check("async_pre_busy", 72'(oDATA_BUSY), 72'd1);
        #1;
        inRESET = 1'b0;
        #1;
        check("async_count", 72'(oCOUNT), 72'd0);
        check("async_valid", 72'(oDATA_VALID), 72'd0);
        check("async_busy",  72'(oDATA_BUSY), 72'd0);
        check("async_data",  oDATA, 72'd0);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        iDATA_BUSY = 1'b0;
        push_word(cw[2]);
        check("async_resume_data",  oDATA, cw[2]);
        check("async_resume_class", 72'(oDATA_CLASS), 72'd1);
        tick();
        check("async_resume_drain", 72'(oCOUNT), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
